shift_register_8bit: RTL and testbench



---
 rtl/shift_register_pkg.sv | 15 +
 rtl/sr_bit_cell.sv | 24 ++
 rtl/shift_register_8bit.sv | 61 ++++++
 tb/tb_shift_register_8bit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/shift_register_pkg.sv
// Shared constants and helpers for the parallel-load / serial-shift register.
// Mode encodings for SH_LD and the width of the optional shift counter.
package shift_register_pkg;

  localparam int SR_WIDTH_DEFAULT = 8;

  localparam logic SR_MODE_LOAD  = 1'b0;
  localparam logic SR_MODE_SHIFT = 1'b1;

  // Counter must hold 0..width inclusive.
  function automatic int sr_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sr_bit_cell.sv
// One storage bit: synchronous clear, then parallel load, then shift from
// the upper neighbour.
module sr_bit_cell
  import shift_register_pkg::*;
(
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_mode,
  input  logic i_load_d,
  input  logic i_shift_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_clr)                      r_q <= 1'b0;
    else if (i_mode == SR_MODE_LOAD) r_q <= i_load_d;
    else                            r_q <= i_shift_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_register_8bit.sv
// WIDTH-bit parallel-load / LSB-first shift register built from sr_bit_cell.
// Define SR_BIT_COUNT_EN to add the saturating BIT_CNT / SHIFT_DONE outputs.
module shift_register_8bit
  import shift_register_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] P_DATA_IN,
  input  logic             S_DATA_IN,
  input  logic             SH_LD,
`ifdef SR_BIT_COUNT_EN
  output logic [sr_cnt_w(WIDTH)-1:0] BIT_CNT,
  output logic                       SHIFT_DONE,
`endif
  output logic [WIDTH-1:0] P_DATA_OUT
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_shift_in;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      if (gi == WIDTH - 1) begin : g_top
        assign w_shift_in[gi] = S_DATA_IN;
      end else begin : g_chain
        assign w_shift_in[gi] = w_q[gi+1];
      end

      sr_bit_cell u_cell (
        .i_clk     (CLK),
        .i_clr     (CLR),
        .i_mode    (SH_LD),
        .i_load_d  (P_DATA_IN[gi]),
        .i_shift_d (w_shift_in[gi]),
        .o_q       (w_q[gi])
      );
    end
  endgenerate

  assign P_DATA_OUT = w_q;

`ifdef SR_BIT_COUNT_EN
  localparam int CNT_W = sr_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (CLR)                          r_cnt <= '0;
    else if (SH_LD == SR_MODE_LOAD)   r_cnt <= '0;
    else if (r_cnt != CNT_MAX)        r_cnt <= r_cnt + 1'b1;
  end

  assign BIT_CNT    = r_cnt;
  assign SHIFT_DONE = (r_cnt == CNT_MAX);
`endif

endmodule

// File: tb/tb_shift_register_8bit.sv
// Self-checking bench for shift_register_8bit: directed plan plus random
// traffic against an arithmetic reference model (SR_BIT_COUNT_EN aware).
module tb_shift_register_8bit;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         CLR;
  logic [W-1:0] P_DATA_IN;
  logic         S_DATA_IN;
  logic         SH_LD;
  logic [W-1:0] P_DATA_OUT;
`ifdef SR_BIT_COUNT_EN
  logic [$clog2(W+1)-1:0] BIT_CNT;
  logic                   SHIFT_DONE;
`endif

  bit clk_en = 1'b1;
  always #5 CLK = clk_en ? ~CLK : CLK;

  shift_register_8bit #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .P_DATA_IN  (P_DATA_IN),
    .S_DATA_IN  (S_DATA_IN),
    .SH_LD      (SH_LD),
`ifdef SR_BIT_COUNT_EN
    .BIT_CNT    (BIT_CNT),
    .SHIFT_DONE (SHIFT_DONE),
`endif
    .P_DATA_OUT (P_DATA_OUT)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: register value as a plain integer, counter as an int.
  int m_val = 0;
  int m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit clr, input bit shld, input logic [W-1:0] pin, input bit sin,
                      input string tag);
    CLR = clr; SH_LD = shld; P_DATA_IN = pin; S_DATA_IN = sin;
    @(posedge CLK);
    #1;
    if (clr) begin
      m_val = 0; m_cnt = 0;
    end else if (!shld) begin
      m_val = int'(pin); m_cnt = 0;
    end else begin
      m_val = (m_val >> 1) | (int'(sin) << (W - 1));
      m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
    end
    chk({tag, "_q"}, 32'(P_DATA_OUT), 32'(m_val & ((1 << W) - 1)));
`ifdef SR_BIT_COUNT_EN
    chk({tag, "_cnt"}, 32'(BIT_CNT), 32'(m_cnt));
    chk({tag, "_done"}, 32'(SHIFT_DONE), 32'(m_cnt == W));
`endif
  endtask

  initial begin
    logic [W-1:0] pat;
    logic [W-1:0] zz;
    logic [W-1:0] held;
    zz = 'z;

    // Reset beats load
    step(1, 0, 8'hFF, 0, "reset");
    chk("reset_const", 32'(P_DATA_OUT), 32'h00);

    // Load A5 and shift out LSB-first
    pat = 8'hA5;
    step(0, 0, pat, 0, "loadA5");
    for (int k = 0; k < W; k++) begin
      step(0, 1, zz, 0, "shout");
      chk("shout_bit0", 32'(P_DATA_OUT[0]), 32'(k + 1 < W ? pat[k+1] : 1'b0));
    end
    chk("shout_final", 32'(P_DATA_OUT), 32'h00);
    step(0, 1, zz, 0, "shout9");

    // Shift in 1,1,0,0,1,0,1,0 with Z on parallel input
    step(1, 0, 8'h00, 0, "clr2");
    pat = 8'b0101_0011;
    for (int k = 0; k < W; k++) step(0, 1, zz, pat[k], "shin");
    chk("shin_const", 32'(P_DATA_OUT), 32'h53);

    // Hold with no edges while inputs wiggle
    step(0, 0, 8'h3C, 0, "load3C");
    clk_en = 1'b0;
    SH_LD = 1'b1; S_DATA_IN = 1'b1; CLR = 1'b1;
    #100;
    held = P_DATA_OUT;
    chk("hold", 32'(held), 32'h3C);
    CLR = 1'b0;
    clk_en = 1'b1;

    // Mid-operation clear, then resume shifting
    step(0, 0, 8'hFF, 0, "loadFF");
    for (int k = 0; k < 3; k++) step(0, 1, zz, 1, "midsh");
    step(1, 1, zz, 1, "midclr");
    step(0, 1, zz, 1, "resume");
    chk("resume_const", 32'(P_DATA_OUT), 32'h80);

    // Reload mid-shift
    step(0, 0, 8'h0F, 0, "load0F");
    step(0, 1, zz, 1, "rl_sh");
    step(0, 1, zz, 0, "rl_sh");
    step(0, 0, 8'hC3, 0, "reload");
    chk("reload_const", 32'(P_DATA_OUT), 32'hC3);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           W'($urandom), 1'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
